// File: rtl/sequence_player_pkg.sv
// sequence_player_pkg: shared types and constants for the sequence player (package seq_pkg).
// SEQ_PLAYER_RAMPDOWN_EN adds the RAMP state.
package seq_pkg;
  localparam int SEQ_DATA_W  = 128;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_CNT_W   = 32;
  localparam int RAMP_LO_BIT = 112;
  localparam int RAMP_HI_BIT = 113;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN
`ifdef SEQ_PLAYER_RAMPDOWN_EN
    , S_RAMP
`endif
  } state_e;
endpackage

// File: rtl/sequence_player_if.sv
// sequence_player_if: control, BRAM and step-word signals of the sequence player.
interface sequence_player_if
  import seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic              stop;
  logic              tick;
  logic [ADDR_W:0]   num_steps;
  logic [CNT_W-1:0]  step_len;
  logic [15:0]       num_loops;
  logic [15:0]       ramp_len;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [DATA_W-1:0] bram_rdata;
  logic [DATA_W-1:0] seq_data;
  logic              busy;
  logic [ADDR_W-1:0] step_idx;
  logic [15:0]       loop_cnt;
  logic              done;
  modport master (
    output start, stop, tick, num_steps, step_len, num_loops, ramp_len, bram_rdata,
    input  bram_addr, bram_en, seq_data, busy, step_idx, loop_cnt, done
  );
  modport slave (
    input  start, stop, tick, num_steps, step_len, num_loops, ramp_len, bram_rdata,
    output bram_addr, bram_en, seq_data, busy, step_idx, loop_cnt, done
  );
endinterface

// File: rtl/sequence_player_step_timer.sv
// sequence_step_timer: counts ticks and strobes wrap on the len-th tick (len 0 acts as 1).
module sequence_step_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] len,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  always_comb begin
    last  = (len == '0) ? '0 : len - CNT_W'(1);
    wrap  = tick && (cnt_q == last);
    cnt_d = (clear || wrap) ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays a BRAM step table onto seq_data; SEQ_PLAYER_RAMPDOWN_EN adds a ramp-down tail.
module sequence_player
  import seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = SEQ_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic clk,
  input logic aresetn,
  sequence_player_if.slave sp
);
  state_e            state_q, state_d;
  logic [ADDR_W:0]   num_steps_q;
  logic [CNT_W-1:0]  step_len_q;
  logic [15:0]       num_loops_q;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d, step_idx_q, step_idx_d, nidx;
  logic              bram_en_q, bram_en_d, pf_q, done_q, done_d;
  logic [DATA_W-1:0] seq_data_q, seq_data_d, next_word_q, next_word_d;
  logic [15:0]       loop_cnt_q, loop_cnt_d, lc_inc;
  logic              go, clr, wrap, end_seq, tmr_tick;
  logic [CNT_W-1:0]  tmr_len;
`ifdef SEQ_PLAYER_RAMPDOWN_EN
  localparam logic [DATA_W-1:0] RAMP_MASK = (DATA_W'(1) << RAMP_HI_BIT) | (DATA_W'(1) << RAMP_LO_BIT);
  logic [15:0] ramp_len_q;
  assign tmr_tick = sp.tick && (state_q == S_RUN || state_q == S_RAMP);
  assign tmr_len  = (state_q == S_RAMP) ? CNT_W'(ramp_len_q) : step_len_q;
`else
  assign tmr_tick = sp.tick && (state_q == S_RUN);
  assign tmr_len  = step_len_q;
`endif
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] x);
    return ({1'b0, x} == num_steps_q - (ADDR_W+1)'(1)) ? '0 : x + ADDR_W'(1);
  endfunction
  sequence_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .aresetn(aresetn), .clear(clr), .tick(tmr_tick), .len(tmr_len), .wrap(wrap)
  );
  assign go     = (state_q == S_IDLE) && sp.start && (sp.num_steps != '0);
  assign nidx   = inc(step_idx_q);
  assign lc_inc = loop_cnt_q + 16'd1;
  always_comb begin
    state_d     = state_q;
    bram_addr_d = bram_addr_q;
    bram_en_d   = 1'b0;
    seq_data_d  = seq_data_q;
    next_word_d = (pf_q && state_q == S_RUN) ? sp.bram_rdata : next_word_q;
    step_idx_d  = step_idx_q;
    loop_cnt_d  = loop_cnt_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    end_seq     = 1'b0;
    case (state_q)
      S_IDLE: if (go) begin
        state_d     = S_FETCH;
        bram_addr_d = '0;
        bram_en_d   = 1'b1;
        step_idx_d  = '0;
        loop_cnt_d  = '0;
        clr         = 1'b1;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d     = S_RUN;
        seq_data_d  = sp.bram_rdata;
        bram_addr_d = inc('0);
        bram_en_d   = 1'b1;
      end
      S_RUN:
        if (sp.stop) end_seq = 1'b1;
        else if (wrap) begin
          step_idx_d = nidx;
          if (nidx == '0) loop_cnt_d = lc_inc;
          // the final wrap ends the run instead of showing the prefetched word
          if (nidx == '0 && num_loops_q != '0 && lc_inc == num_loops_q) end_seq = 1'b1;
          else begin
            seq_data_d  = next_word_q;
            bram_addr_d = inc(nidx);
            bram_en_d   = 1'b1;
          end
        end
`ifdef SEQ_PLAYER_RAMPDOWN_EN
      S_RAMP: if (wrap) begin
        seq_data_d = '0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (end_seq) begin
      clr = 1'b1;
`ifdef SEQ_PLAYER_RAMPDOWN_EN
      if (ramp_len_q != '0) begin
        state_d    = S_RAMP;
        seq_data_d = seq_data_q | RAMP_MASK;
      end else
`endif
      begin
        seq_data_d = '0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      state_q     <= S_IDLE;
      num_steps_q <= '0;
      step_len_q  <= '0;
      num_loops_q <= '0;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      pf_q        <= 1'b0;
      seq_data_q  <= '0;
      next_word_q <= '0;
      step_idx_q  <= '0;
      loop_cnt_q  <= '0;
      done_q      <= 1'b0;
`ifdef SEQ_PLAYER_RAMPDOWN_EN
      ramp_len_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      pf_q        <= bram_en_q;
      seq_data_q  <= seq_data_d;
      next_word_q <= next_word_d;
      step_idx_q  <= step_idx_d;
      loop_cnt_q  <= loop_cnt_d;
      done_q      <= done_d;
      if (go) begin
        num_steps_q <= sp.num_steps;
        step_len_q  <= sp.step_len;
        num_loops_q <= sp.num_loops;
`ifdef SEQ_PLAYER_RAMPDOWN_EN
        ramp_len_q  <= sp.ramp_len;
`endif
      end
    end
  assign sp.bram_addr = bram_addr_q;
  assign sp.bram_en   = bram_en_q;
  assign sp.seq_data  = seq_data_q;
  assign sp.busy      = (state_q != S_IDLE);
  assign sp.step_idx  = step_idx_q;
  assign sp.loop_cnt  = loop_cnt_q;
  assign sp.done      = done_q;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: scoreboard bench for sequence_player; the ramp case runs with SEQ_PLAYER_RAMPDOWN_EN.
module tb_sequence_player;
  import seq_pkg::*;
  localparam logic [127:0] WA = 128'hA1A1_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [127:0] WB = 128'hB2B2_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [127:0] WC = 128'hC3C3_0000_0000_0000_0000_0000_0000_00C3;
  typedef struct {
    logic [127:0] d;
    bit           dn;
    int           lc;
    int           idx;
    int           tk;
  } exp_t;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic tick_en = 1'b0;
  logic man_tick = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int bram_reads = 0;
  exp_t q[$];
  logic [127:0] mem [0:1023];
  always #5 clk = ~clk;
  sequence_player_if sp();
  sequence_player dut (.clk(clk), .aresetn(aresetn), .sp(sp));
  always @(posedge clk) if (sp.bram_en) sp.bram_rdata <= mem[sp.bram_addr];

  initial forever begin
    @(posedge clk);
    #1 cyc++;
    sp.tick = tick_en ? (cyc % 4 == 0) : man_tick;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // monitor: every change of seq_data or done pulse consumes one expected entry
  initial begin
    logic [127:0] prev;
    int tk;
    exp_t e;
    prev = '0;
    tk = 0;
    forever begin
      @(negedge clk);
      if (sp.bram_en) bram_reads++;
      if (sp.seq_data !== prev || sp.done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected got=%h done=%b", sp.seq_data, sp.done);
        end else begin
          e = q.pop_front();
          chk("sb_data", sp.seq_data, e.d);
          chk("sb_done", 128'(sp.done), 128'(e.dn));
          if (e.lc >= 0) chk("sb_loop_cnt", 128'(sp.loop_cnt), 128'(e.lc));
          if (e.idx >= 0) chk("sb_step_idx", 128'(sp.step_idx), 128'(e.idx));
          if (e.tk >= 0) chk("sb_hold_ticks", 128'(tk), 128'(e.tk));
        end
        tk = 0;
      end
      if (sp.tick) tk++;
      prev = sp.seq_data;
    end
  end

  task automatic push(input logic [127:0] d, input bit dn, input int lc, input int idx, input int tk);
    exp_t e;
    e.d = d; e.dn = dn; e.lc = lc; e.idx = idx; e.tk = tk;
    q.push_back(e);
  endtask

  task automatic start_seq(input int ns, input int sl, input int nl, input int rl);
    @(posedge clk);
    #1;
    sp.num_steps = 11'(ns);
    sp.step_len  = 32'(sl);
    sp.num_loops = 16'(nl);
    sp.ramp_len  = 16'(rl);
    sp.start     = 1'b1;
    @(posedge clk);
    #1 sp.start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1 sp.stop = 1'b1;
    @(posedge clk);
    #1 sp.stop = 1'b0;
  endtask

  task automatic wait_seq(input logic [127:0] v, input string nm);
    int n = 0;
    while (sp.seq_data !== v && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, sp.seq_data, v);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sp.busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(sp.busy), 128'(0));
  endtask

  initial begin
    int r0;
    sp.start = 1'b0; sp.stop = 1'b0; sp.tick = 1'b0;
    sp.num_steps = '0; sp.step_len = '0; sp.num_loops = '0; sp.ramp_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = WA; mem[1] = WB; mem[2] = WC;
    #23;
    chk("rst_seq_data", sp.seq_data, '0);
    chk("rst_busy", 128'(sp.busy), 128'(0));
    chk("rst_bram_en", 128'(sp.bram_en), 128'(0));
    chk("rst_bram_addr", 128'(sp.bram_addr), 128'(0));
    chk("rst_done", 128'(sp.done), 128'(0));
    @(negedge clk) aresetn = 1'b1;

    // three steps of four ticks, two passes
    tick_en = 1'b1;
    push(WA, 0, 0, 0, -1); push(WB, 0, 0, 1, 4); push(WC, 0, 0, 2, 4);
    push(WA, 0, 1, 0, 4);  push(WB, 0, 1, 1, 4); push(WC, 0, 1, 2, 4);
    push('0, 1, 2, -1, 4);
    start_seq(3, 4, 2, 0);
    wait_idle("t1_idle");
    chk("t1_loop_cnt", 128'(sp.loop_cnt), 128'(2));
    @(posedge clk);
    #1 chk("t1_done_single", 128'(sp.done), 128'(0));

    // single step, infinite loops, start latency, start while busy, stop
    push(WA, 0, 0, 0, -1);
`ifdef SEQ_PLAYER_RAMPDOWN_EN
    start_seq(1, 2, 0, 0);
`else
    start_seq(1, 2, 0, 5);
`endif
    chk("t2_busy", 128'(sp.busy), 128'(1));
    chk("t2_bram_en", 128'(sp.bram_en), 128'(1));
    chk("t2_bram_addr0", 128'(sp.bram_addr), 128'(0));
    @(posedge clk);
    #1 chk("t2_lat_n1", sp.seq_data, '0);
    @(posedge clk);
    #1 chk("t2_lat_n2", sp.seq_data, WA);
    repeat (20) @(posedge clk);
    #1 chk("t2_persist", sp.seq_data, WA);
    sp.num_steps = 11'd3;
    sp.start = 1'b1;
    @(posedge clk);
    #1 sp.start = 1'b0;
    chk("t4_busy_start_seq", sp.seq_data, WA);
    chk("t4_busy_start_idx", 128'(sp.step_idx), 128'(0));
    push('0, 1, -1, -1, -1);
    pulse_stop();
    chk("t2_stop_zero", sp.seq_data, '0);
    chk("t2_stop_done", 128'(sp.done), 128'(1));
    chk("t2_stop_busy", 128'(sp.busy), 128'(0));
    r0 = bram_reads;
    start_seq(0, 2, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("t4_zero_steps_busy", 128'(sp.busy), 128'(0));
    chk("t4_zero_steps_reads", 128'(bram_reads), 128'(r0));

    // stop on the boundary tick wins over the next word
    tick_en = 1'b0;
    push(WA, 0, 0, 0, -1);
    start_seq(2, 2, 0, 0);
    wait_seq(WA, "t3_first");
    repeat (2) @(posedge clk);
    man_tick = 1'b1;
    @(posedge clk);
    man_tick = 1'b0;
    repeat (3) @(posedge clk);
    push('0, 1, 0, 0, 2);
    man_tick = 1'b1;
    #1 sp.stop = 1'b1;
    @(posedge clk);
    man_tick = 1'b0;
    #1 sp.stop = 1'b0;
    chk("t3_stop_boundary", sp.seq_data, '0);
    tick_en = 1'b1;

`ifdef SEQ_PLAYER_RAMPDOWN_EN
    // ramp-down tail holds the word with the ramp bits set for ramp_len ticks
    mem[5] = mem[0];
    mem[0] = 128'h1234;
    push(128'h1234, 0, 0, 0, -1);
    push(128'h1234 | (128'h3 << 112), 0, -1, -1, -1);
    push('0, 1, -1, -1, 5);
    start_seq(1, 8, 0, 5);
    wait_seq(128'h1234, "t5_word");
    pulse_stop();
    chk("t5_ramp_word", sp.seq_data, 128'h0003_0000_0000_0000_0000_0000_0000_1234);
    chk("t5_ramp_busy", 128'(sp.busy), 128'(1));
    repeat (3) @(posedge clk);
    pulse_stop();
    chk("t5_stop_ignored", sp.seq_data, 128'h0003_0000_0000_0000_0000_0000_0000_1234);
    wait_idle("t5_idle");
    mem[0] = mem[5];
`endif

    // asynchronous reset mid-step, then a clean replay from step 0
    push(WA, 0, 0, 0, -1); push(WB, 0, 0, 1, 4);
    start_seq(3, 4, 0, 0);
    wait_seq(WB, "t6_second");
    repeat (5) @(posedge clk);
    push('0, 0, -1, -1, -1);
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_rst_seq_data", sp.seq_data, '0);
    chk("t6_rst_busy", 128'(sp.busy), 128'(0));
    chk("t6_rst_bram_en", 128'(sp.bram_en), 128'(0));
    chk("t6_rst_step_idx", 128'(sp.step_idx), 128'(0));
    chk("t6_rst_loop_cnt", 128'(sp.loop_cnt), 128'(0));
    chk("t6_rst_done", 128'(sp.done), 128'(0));
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    push(WA, 0, 0, 0, -1);
    start_seq(3, 4, 0, 0);
    wait_seq(WA, "t6_replay");
    chk("t6_replay_idx", 128'(sp.step_idx), 128'(0));
    push('0, 1, -1, -1, -1);
    pulse_stop();
    repeat (5) @(posedge clk);
    #1 chk("sb_drained", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
